// File: rtl/pci_cfg_requester.sv
// pci_cfg_requester
//   Initiator side of the cfg_* configuration register handshake. Host-side
//   requests are buffered in a small FIFO and issued one at a time to the
//   config-space responder. Read data and write-error / timeout status come
//   back on a valid/ready response channel.
//
//   Optional feature macro: PCI_CFG_TIMEOUT_EN
//     defined   : a watchdog aborts an access after TIMEOUT_CYCLES cycles of
//                 cfg_enable without cfg_done (rsp_rdata=FFFF_FFFF, rsp_timeout=1)
//     undefined : no watchdog, ISSUE waits indefinitely, rsp_timeout stays 0
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready = FIFO not full)
//   req_write/offset/be/wdata request payload
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    response payload
//   busy                     FSM not IDLE or FIFO non-empty
//   cfg_enable/iswrite/offset/be/write_val   registered access to responder
//   cfg_read_val/done/w_err  responder completion inputs
module pci_cfg_requester #(
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [5:0]  req_offset,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [3:0]  cfg_be,
  output logic [31:0] cfg_write_val,
  input  logic [31:0] cfg_read_val,
  input  logic        cfg_done,
  input  logic        cfg_w_err
);

  localparam int AW = $clog2(REQ_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  state_t          state;

  logic            fifo_write [REQ_FIFO_DEPTH];
  logic [5:0]      fifo_offset[REQ_FIFO_DEPTH];
  logic [3:0]      fifo_be    [REQ_FIFO_DEPTH];
  logic [31:0]     fifo_wdata [REQ_FIFO_DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            push;
  logic            pop;
  logic            fifo_vld_p0;

`ifdef PCI_CFG_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic            unused_tmo_param;
  assign unused_tmo_param = (TIMEOUT_CYCLES != 0);
`endif

  // A full FIFO never accepts, even when the FSM pops in the same cycle.
  assign full      = (count == (AW+1)'(REQ_FIFO_DEPTH));
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && fifo_vld_p0;
  assign busy      = (state != IDLE) || (count != '0);

  // ---- Stage p0: request FIFO write (payload storage, not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write [wr_ptr] <= req_write;
      fifo_offset[wr_ptr] <= req_offset;
      fifo_be    [wr_ptr] <= req_be;
      fifo_wdata [wr_ptr] <= req_wdata;
    end
  end

  // FIFO control. fifo_vld_p0 is a registered "head available" flag: it
  // delays the FSM's view of a new entry by one cycle, so an access starts
  // two edges after the request handshake. A pop clears it so the flag is
  // never stale when the FSM next returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      fifo_vld_p0 <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      fifo_vld_p0 <= (count != '0) && !pop;
    end
  end

  // ---- Stage p1: access FSM with registered cfg_* and rsp_* outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_enable    <= 1'b0;
      cfg_iswrite   <= 1'b0;
      cfg_offset    <= '0;
      cfg_be        <= '0;
      cfg_write_val <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
`ifdef PCI_CFG_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // cfg_done seen here is a leftover from the previous access.
          if (fifo_vld_p0) begin
            cfg_iswrite   <= fifo_write [rd_ptr];
            cfg_offset    <= fifo_offset[rd_ptr];
            cfg_be        <= fifo_be    [rd_ptr];
            cfg_write_val <= fifo_wdata [rd_ptr];
            cfg_enable    <= 1'b1;
`ifdef PCI_CFG_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_done) begin
            cfg_enable  <= 1'b0;
            rsp_rdata   <= cfg_iswrite ? 32'h0 : cfg_read_val;
            rsp_err     <= cfg_w_err && cfg_iswrite;
            rsp_timeout <= 1'b0;
            state       <= RELEASE;
          end
`ifdef PCI_CFG_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // Watchdog abort; a late cfg_done is absorbed in RELEASE.
            cfg_enable  <= 1'b0;
            rsp_rdata   <= 32'hFFFF_FFFF;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b1;
            state       <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Responder drops cfg_done one cycle after cfg_enable falls.
          if (!cfg_done) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
